mux4_rr_sched: RTL
==================

Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares a 4-input registered mux (WIDTH-bit output register with write enable) among 4 requesters.
- Each cycle it picks at most one requester, drives the mux select and register write enable, and tracks whether the output register holds unconsumed data.
- Consumer side uses a valid/ready handshake.
- The block sits beside the registered mux and controls it. It carries no data itself.

Parameters:
- CNT_WIDTH, 16, width of the wrapping transfer counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  4  request per requester; held high until granted
- en_mask  input  4  per-requester enable; req[i] ignored while en_mask[i]=0
- grant  output  4  one-hot; grant[i]=1 means requester i's data is written this cycle
- sel  output  2  mux select, binary index of granted requester
- wr_en  output  1  output register write enable
- out_valid  output  1  output register holds unconsumed data
- out_ready  input  1  consumer accepts data when out_valid && out_ready
- xfer_cnt  output  CNT_WIDTH  number of completed consumer transfers, wraps

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - out_valid=0
  - round-robin pointer ptr=0
  - xfer_cnt=0
  - grant, sel and wr_en are combinational and evaluate to 0 while rst=1.
- Eligible set: elig = req & en_mask.
- Slot can accept when: accept = !out_valid || out_ready. This gives full-throughput pass-through.
- Grant (combinational, same cycle):
  - If accept && elig!=0, grant = first set bit of elig searched from index ptr upward, wrapping 3->0.
  - Otherwise grant = 0.
- wr_en = |grant. sel = index of the granted bit; sel=0 when there is no grant.
- Latency: data on the selected mux input is captured at the edge ending the grant cycle. out_valid=1 from the next cycle.
- Requester contract: req[i] and its data are stable until grant[i] is seen. Requester i may drop req[i] the cycle after grant[i].
- Pointer: on a grant to index g, ptr <= (g+1) mod 4. With no grant, ptr holds.
- States, encoded by out_valid:
  - EMPTY (0): any grant -> FULL. No grant -> EMPTY.
  - FULL (1): out_ready=0 -> stay FULL, no grant, register holds.
  - FULL (1): out_ready=1 with a grant -> stay FULL (old word consumed, new word written at the same edge).
  - FULL (1): out_ready=1 with no grant -> EMPTY.
- xfer_cnt increments by 1 on each cycle with out_valid && out_ready. It wraps at 2^CNT_WIDTH-1 -> 0.
- out_ready while EMPTY has no effect and does not count.
- Disabled requesters: en_mask change takes effect the same cycle. A masked requester is never granted, even if the pointer points at it.
- Fairness: with all 4 requesting continuously and out_ready=1, the grant order is 0,1,2,3,0,… One grant per cycle.
- Reset mid-operation: rst=1 forces EMPTY, ptr=0 and xfer_cnt=0 at the next edge. Any pending word is discarded. No grant is issued in the rst cycle.

Decomposition:
- Shared package holds:
  - NUM_REQ=4
  - SEL_W=2
  - state encoding constants S_EMPTY/S_FULL
  - a function onehot_to_idx (4->2)
- One sub-module is natural: rr_pick4. It is a combinational rotating priority picker with inputs elig[3:0], ptr[1:0] and valid, and outputs grant[3:0] and idx[1:0].
- The pointer register, slot state and counter stay in mux4_rr_sched.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0, wr_en=0, out_valid=0, xfer_cnt=0; first grant after release goes to requester 0 (sel=0).
- Round-robin: req=4'b1111, en_mask=4'b1111, out_ready=1 for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3; out_valid=1 from cycle 2; xfer_cnt=7 after cycle 8.
- Backpressure: req=4'b0100, out_ready=0 -> one grant (sel=2), then grant=0 while out_valid=1; raise out_ready -> xfer_cnt+1. Next grant only in the same cycle as that transfer.
- Masking/skip: ptr=1, req=4'b1011, en_mask=4'b1101 -> grant=4'b1000 (sel=3); next grant 4'b0001; requester 1 is never granted.
- Drain to empty: single word written, out_ready=1, req=0 -> out_valid falls after one transfer; xfer_cnt=1; further out_ready pulses leave the count at 1.
- Counter wrap: CNT_WIDTH=4, 17 back-to-back transfers -> xfer_cnt reads 15 then 0 then 1.
- Mid-operation reset: rst asserted while FULL with out_ready=0 -> next cycle out_valid=0, ptr=0, xfer_cnt=0, no transfer counted.

Source files
------------

// File: rtl/mux4_rr_sched_pkg.sv
// Shared types and helpers for the 4-way round-robin mux scheduler.
package mux4_rr_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  function automatic logic [SEL_W-1:0] onehot_to_idx(
    input logic [NUM_REQ-1:0] oh
  );
    logic [SEL_W-1:0] r;
    r = '0;
    unique case (1'b1)
      oh[0]:   r = 2'd0;
      oh[1]:   r = 2'd1;
      oh[2]:   r = 2'd2;
      oh[3]:   r = 2'd3;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mux4_rr_sched_pick.sv
// Rotating-priority picker: first eligible index at or above ptr, wrapping.
module rr_pick4
  import mux4_rr_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  logic [SEL_W-1:0]   ptr,
  input  logic               valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   idx
);

  logic             found;
  logic [SEL_W-1:0] j;

  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = ptr + SEL_W'(k);
      if (valid && !found && elig[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign idx = onehot_to_idx(grant);

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving select/write-enable of a shared
// registered 4:1 mux, with a valid/ready consumer side.
module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   en_mask,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_W-1:0]     sel,
  output logic                 wr_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  slot_e            state_q, state_d;
  logic [SEL_W-1:0] ptr_q;
  logic             accept;
  logic             fire;

  assign out_valid = (state_q == S_FULL);
  assign accept    = !out_valid || out_ready;
  assign fire      = out_valid && out_ready;

  rr_pick4 u_pick (
    .elig  (req & en_mask),
    .ptr   (ptr_q),
    .valid (accept && !rst),
    .grant (grant),
    .idx   (sel)
  );

  assign wr_en = |grant;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (wr_en) state_d = S_FULL;
      S_FULL:  if (out_ready && !wr_en) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      ptr_q    <= '0;
      xfer_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) ptr_q <= sel + 2'd1;
      if (fire) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule
